// File: rtl/md_issue_if.sv
// Decode-to-multiply/divide issue bus.
// The master side is the decode stage; the slave side is md_issue_ctrl.
interface md_issue_if #(
  parameter int CNT_W = 32
);
  logic             d_valid;
  logic [3:0]       d_md_op;
  logic [31:0]      d_rs_val;
  logic [31:0]      d_rt_val;
  logic             flush;
  logic             stall_d;
  logic             md_start;
  logic [3:0]       md_c;
  logic [31:0]      md_data1;
  logic [31:0]      md_data2;
  logic [1:0]       mf_sel;
  logic             div0;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output d_valid, d_md_op, d_rs_val, d_rt_val, flush,
    input  stall_d, md_start, md_c, md_data1, md_data2, mf_sel, div0, stall_cnt
  );

  modport slave (
    input  d_valid, d_md_op, d_rs_val, d_rt_val, flush,
    output stall_d, md_start, md_c, md_data1, md_data2, mf_sel, div0, stall_cnt
  );
endinterface

// File: rtl/md_issue_ctrl.sv
// Execute-stage issue controller in front of the multiply/divide unit.
// Registers opcode and operands, pulses md_start for mult/div, shadows the
// unit's busy window with a down-counter and stalls decode on md ops while
// that window is open. stall_cnt is a saturating performance counter.
module md_issue_ctrl #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10,
  parameter int CNT_W   = 32
) (
  input  logic        clk,
  input  logic        reset,
  md_issue_if.slave   bus
);

  localparam int LAT_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int LAT_W   = $clog2(LAT_MAX + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic             start_q, start_d;
  logic [3:0]       c_q, c_d;
  logic [31:0]      d1_q, d1_d;
  logic [31:0]      d2_q, d2_d;
  logic [1:0]       mf_q, mf_d;
  logic             div0_q, div0_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic is_md;
  logic stall;
  logic accept;

  // Decode qualification, stall and next-state for all issue registers.
  always_comb begin
    is_md  = bus.d_valid && (bus.d_md_op != 4'd0) && (bus.d_md_op <= OP_MFLO);
    stall  = is_md && (cnt_q != '0);
    accept = is_md && !stall && !bus.flush;

    start_d = 1'b0;
    c_d     = 4'd0;
    mf_d    = 2'd0;
    div0_d  = 1'b0;
    d1_d    = d1_q;
    d2_d    = d2_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - LAT_W'(1) : cnt_q;
    stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1)
                                                 : stall_cnt_q;

    // A load only happens with cnt_q == 0, so it never races the decrement.
    if (accept) begin
      case (bus.d_md_op)
        OP_MULT, OP_MULTU: begin
          start_d = 1'b1;
          c_d     = bus.d_md_op;
          d1_d    = bus.d_rs_val;
          d2_d    = bus.d_rt_val;
          cnt_d   = LAT_W'(MUL_LAT);
        end
        OP_DIV, OP_DIVU: begin
          start_d = 1'b1;
          c_d     = bus.d_md_op;
          d1_d    = bus.d_rs_val;
          d2_d    = bus.d_rt_val;
          cnt_d   = LAT_W'(DIV_LAT);
          div0_d  = (bus.d_rt_val == 32'd0);
        end
        OP_MTHI, OP_MTLO: begin
          c_d  = bus.d_md_op;
          d1_d = bus.d_rs_val;
        end
        OP_MFHI: mf_d = 2'd1;
        OP_MFLO: mf_d = 2'd2;
        default: ;
      endcase
    end
  end

  // Issue registers; reset kills any operation in flight and idles the unit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      start_q     <= 1'b0;
      c_q         <= 4'd0;
      d1_q        <= 32'd0;
      d2_q        <= 32'd0;
      mf_q        <= 2'd0;
      div0_q      <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      start_q     <= start_d;
      c_q         <= c_d;
      d1_q        <= d1_d;
      d2_q        <= d2_d;
      mf_q        <= mf_d;
      div0_q      <= div0_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall_d   = stall;
  assign bus.md_start  = start_q;
  assign bus.md_c      = c_q;
  assign bus.md_data1  = d1_q;
  assign bus.md_data2  = d2_q;
  assign bus.mf_sel    = mf_q;
  assign bus.div0      = div0_q;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Bench for md_issue_ctrl: directed scenarios followed by a random phase,
// all checked against a cycle-indexed reference model. A second instance
// with a 4-bit stall counter shares the stimulus so saturation is reachable.
module tb_md_issue_ctrl;
  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  md_issue_if #(.CNT_W(32)) bus ();
  md_issue_if #(.CNT_W(4))  bus_s ();

  md_issue_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(32)) dut (
    .clk(clk), .reset(reset_n), .bus(bus));
  md_issue_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)) dut_s (
    .clk(clk), .reset(reset_n), .bus(bus_s));

  assign bus_s.d_valid  = bus.d_valid;
  assign bus_s.d_md_op  = bus.d_md_op;
  assign bus_s.d_rs_val = bus.d_rs_val;
  assign bus_s.d_rt_val = bus.d_rt_val;
  assign bus_s.flush    = bus.flush;

  int checks = 0;
  int errors = 0;

  // Reference model: the unit is free from edge index free_edge onward.
  longint      edge_n = 0;
  longint      free_edge = 0;
  longint      stall_total = 0;
  logic        e_start = 0;
  logic [3:0]  e_c = 0;
  logic [31:0] e_d1 = 0;
  logic [31:0] e_d2 = 0;
  logic [1:0]  e_mf = 0;
  logic        e_div0 = 0;
  logic        last_stall = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] rs,
                       input logic [31:0] rt, input logic fl);
    bus.d_valid  = v;
    bus.d_md_op  = op;
    bus.d_rs_val = rs;
    bus.d_rt_val = rt;
    bus.flush    = fl;
  endtask

  task automatic check_outputs();
    longint sat_s;
    sat_s = (stall_total > 15) ? 15 : stall_total;
    chk("md_start",  {31'd0, bus.md_start}, {31'd0, e_start});
    chk("md_c",      {28'd0, bus.md_c},     {28'd0, e_c});
    chk("md_data1",  bus.md_data1, e_d1);
    chk("md_data2",  bus.md_data2, e_d2);
    chk("mf_sel",    {30'd0, bus.mf_sel},   {30'd0, e_mf});
    chk("div0",      {31'd0, bus.div0},     {31'd0, e_div0});
    chk("stall_cnt", bus.stall_cnt, 32'(stall_total));
    chk("stall_cnt_sat4", {28'd0, bus_s.stall_cnt}, 32'(sat_s));
  endtask

  // One clock: check stall_d for the presented inputs, advance the model,
  // take the edge and compare registered outputs.
  task automatic step();
    logic is_md, busy, exp_st;
    #1;
    is_md  = bus.d_valid && (bus.d_md_op >= 4'd1) && (bus.d_md_op <= 4'd8);
    busy   = (edge_n < free_edge);
    exp_st = is_md && busy;
    chk("stall_d", {31'd0, bus.stall_d}, {31'd0, exp_st});
    last_stall = bus.stall_d;
    if (exp_st) stall_total++;
    e_start = 0; e_c = 0; e_mf = 0; e_div0 = 0;
    if (is_md && !busy && !bus.flush) begin
      case (bus.d_md_op)
        4'd1, 4'd2: begin
          e_start = 1; e_c = bus.d_md_op; e_d1 = bus.d_rs_val; e_d2 = bus.d_rt_val;
          free_edge = edge_n + MUL_LAT + 1;
        end
        4'd3, 4'd4: begin
          e_start = 1; e_c = bus.d_md_op; e_d1 = bus.d_rs_val; e_d2 = bus.d_rt_val;
          e_div0 = (bus.d_rt_val == 0);
          free_edge = edge_n + DIV_LAT + 1;
        end
        4'd5, 4'd6: begin
          e_c = bus.d_md_op; e_d1 = bus.d_rs_val;
        end
        4'd7: e_mf = 1;
        default: e_mf = 2;
      endcase
    end
    edge_n++;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    #1;
    chk("rst_md_start",  {31'd0, bus.md_start}, 32'd0);
    chk("rst_md_c",      {28'd0, bus.md_c}, 32'd0);
    chk("rst_md_data1",  bus.md_data1, 32'd0);
    chk("rst_md_data2",  bus.md_data2, 32'd0);
    chk("rst_mf_sel",    {30'd0, bus.mf_sel}, 32'd0);
    chk("rst_div0",      {31'd0, bus.div0}, 32'd0);
    chk("rst_stall_cnt", bus.stall_cnt, 32'd0);
    repeat (n) @(posedge clk);
    #1;
    reset_n = 1'b1;
    free_edge = 0; stall_total = 0;
    e_start = 0; e_c = 0; e_d1 = 0; e_d2 = 0; e_mf = 0; e_div0 = 0;
  endtask

  task automatic wait_idle();
    drive(0, 4'd0, 32'd0, 32'd0, 0);
    repeat (DIV_LAT + 2) step();
  endtask

  // Present the current op until it is accepted; returns stall cycles seen.
  task automatic hold_until_accept(output int nst);
    nst = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!last_stall) break;
      nst++;
    end
  endtask

  initial begin
    int nst;
    drive(0, 4'd0, 32'd0, 32'd0, 0);
    #2;
    do_reset(2);

    // Back-to-back mult
    drive(1, 4'd1, 32'd3, 32'd7, 0);
    step();
    chk("mult1_start", {31'd0, bus.md_start}, 32'd1);
    chk("mult1_data1", bus.md_data1, 32'd3);
    chk("mult1_data2", bus.md_data2, 32'd7);
    drive(1, 4'd1, 32'd5, 32'd9, 0);
    hold_until_accept(nst);
    chk("mult_stall_cycles", nst, MUL_LAT);
    chk("mult2_start", {31'd0, bus.md_start}, 32'd1);

    // div by zero followed by mflo
    wait_idle();
    drive(1, 4'd3, 32'd100, 32'd0, 0);
    step();
    chk("div0_pulse", {31'd0, bus.div0}, 32'd1);
    drive(1, 4'd8, 32'd0, 32'd0, 0);
    hold_until_accept(nst);
    chk("mflo_stall_cycles", nst, DIV_LAT);
    chk("mflo_sel", {30'd0, bus.mf_sel}, 32'd2);
    drive(0, 4'd0, 32'd0, 32'd0, 0);
    step();

    // mthi then mfhi while idle
    drive(1, 4'd5, 32'hDEADBEEF, 32'h1234, 0);
    step();
    chk("mthi_c", {28'd0, bus.md_c}, 32'd5);
    chk("mthi_data1", bus.md_data1, 32'hDEADBEEF);
    drive(1, 4'd7, 32'd0, 32'd0, 0);
    step();
    chk("mfhi_nostall", {31'd0, last_stall}, 32'd0);
    chk("mfhi_sel", {30'd0, bus.mf_sel}, 32'd1);

    // Non-md op during divide, then flushed md op while idle
    drive(1, 4'd4, 32'd50, 32'd7, 0);
    step();
    drive(1, 4'd0, 32'd1, 32'd1, 0);
    repeat (DIV_LAT + 1) step();
    drive(1, 4'd1, 32'd1, 32'd1, 1);
    step();
    chk("flush_nostart", {31'd0, bus.md_start}, 32'd0);
    drive(1, 4'd7, 32'd0, 32'd0, 0);
    step();
    chk("after_flush_nostall", {31'd0, last_stall}, 32'd0);

    // Reset three cycles into a divide
    drive(1, 4'd3, 32'd9, 32'd3, 0);
    step();
    drive(0, 4'd0, 32'd0, 32'd0, 0);
    step();
    step();
    do_reset(2);
    drive(1, 4'd1, 32'd2, 32'd2, 0);
    step();
    chk("post_rst_nostall", {31'd0, last_stall}, 32'd0);
    chk("post_rst_start", {31'd0, bus.md_start}, 32'd1);

    // Two full divide stall windows drive the 4-bit counter into saturation
    for (int k = 0; k < 2; k++) begin
      wait_idle();
      drive(1, 4'd4, 32'd77, 32'd5, 0);
      step();
      drive(1, 4'd2, 32'd6, 32'd8, 0);
      hold_until_accept(nst);
    end
    chk("stall_cnt_20", bus.stall_cnt, 32'd20);
    chk("stall_cnt_sat", {28'd0, bus_s.stall_cnt}, 32'd15);
    drive(1, 4'd1, 32'd0, 32'd0, 0);
    repeat (3) step();
    chk("stall_cnt_sat_hold", {28'd0, bus_s.stall_cnt}, 32'd15);

    // Random phase
    for (int i = 0; i < 400; i++) begin
      logic [31:0] rt;
      rt = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      drive($urandom_range(0, 4) != 0, 4'($urandom_range(0, 15)), $urandom, rt,
            $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 199) == 0) do_reset(1);
      else step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/md_issue_ctrl.md
Name: md_issue_ctrl

Overview:
- Execute-stage issue controller that sits directly upstream of the E-stage multiply/divide unit.
- Accepts mult/div/mthi/mtlo/mfhi/mflo operations from the decode stage.
- Registers operands and opcode, and drives a one-cycle start pulse into the multiply/divide unit.
- Tracks the unit's busy window with its own latency counter and stalls decode while a result is pending; also counts stall cycles for performance reporting.

Parameters:
MUL_LAT, 5, busy cycles after a mult/multu start
DIV_LAT, 10, busy cycles after a div/divu start
CNT_W, 32, width of the stall performance counter

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
d_valid  input  1  decode slot holds a valid instruction
d_md_op  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9-15 none
d_rs_val  input  32  rs operand (forwarded)
d_rt_val  input  32  rt operand (forwarded)
flush  input  1  synchronous kill of the decode-slot operation at this edge
stall_d  output  1  hold decode; combinational
md_start  output  1  one-cycle start pulse to the multiply/divide unit
md_c  output  4  registered opcode to the unit (same encoding as d_md_op)
md_data1  output  32  registered rs value
md_data2  output  32  registered rt value
mf_sel  output  2  0 none, 1 read HI, 2 read LO; valid for one cycle
div0  output  1  one-cycle pulse coincident with md_start when a div/divu is issued with rt == 0
stall_cnt  output  CNT_W  saturating count of cycles with stall_d high

Behaviour:
- Reset (reset == 0, asynchronous): md_start, md_c, md_data1, md_data2, mf_sel, div0 and stall_cnt all cleared to 0; internal busy counter cnt cleared to 0. Reset overrides everything, including an operation in flight; the unit is then treated as idle.
- is_md = d_valid && d_md_op in 1..8.
- stall_d = is_md && (cnt != 0). Non-md instructions never stall.
- Acceptance at a rising edge requires accept = is_md && !stall_d && !flush.
- On accept, ops 1-4:
  - md_start <= 1; md_c <= op; md_data1 <= d_rs_val; md_data2 <= d_rt_val.
  - cnt <= MUL_LAT for ops 1-2, DIV_LAT for ops 3-4.
- On accept, ops 5-6:
  - md_start <= 0; md_c <= op; md_data1 <= d_rs_val; cnt unchanged (0).
  - The unit writes HI/LO in that cycle.
- On accept, ops 7-8: mf_sel <= 1 or 2; md_c <= 0.
- No accept: md_start <= 0, md_c <= 0, mf_sel <= 0, div0 <= 0; md_data1/md_data2 hold their values.
- cnt: decrements by 1 each edge while nonzero and no load is occurring. A load and a decrement never coincide, because a load requires cnt == 0.
- Timing: cnt reaches 0 exactly LAT edges after the start edge. An md op presented in that same cycle is accepted at the next edge, so back-to-back mult costs MUL_LAT stall cycles.
- Boundaries:
  - flush while stalled: no accept; stall_d still reflects cnt; cnt keeps counting.
  - flush never aborts an operation already started.
  - div0: issue proceeds normally; the result is unit-defined; div0 pulses once.
- stall_cnt: increments on each edge where stall_d == 1, independent of flush, and saturates at all-ones with no wrap.
- Latency from decode accept to md_start: 1 cycle. md_start is high for exactly one cycle per mult/div.

Test Plan:
- Reset released, d_valid=1, op=1, rs=3, rt=7 -> next cycle md_start=1, md_c=1, md_data1=3, md_data2=7; stall_d=1 for the following 5 cycles against a second mult; second md_start occurs 6 cycles after the first.
- div (op=3), rs=100, rt=0 -> md_start=1 and div0=1 in the same cycle; an mflo presented next is stalled for 10 cycles, then mf_sel=2 for one cycle.
- mthi rs=0xDEADBEEF while idle -> md_c=5, md_data1=0xDEADBEEF, md_start=0, no stall; an immediately following mfhi -> mf_sel=1 with no stall.
- Non-md instruction (op=0) presented during a divide's busy window -> stall_d=0 throughout; md op presented with flush=1 while idle -> no md_start, cnt stays 0.
- Reset driven low 3 cycles into a divide -> all outputs 0 immediately (asynchronous); after release, a new mult issues with no stall.
- Force stall_cnt to 0xFFFFFFFE, hold stall for 3 cycles -> reads 0xFFFFFFFF and holds there without wrapping.
